// File: rtl/booth_dot_accum_if.sv
// Stream bundle for booth_dot_accum.
//   Input stream  : in_valid / in_ready, in_product (8-bit signed), in_last
//   Output stream : out_valid / out_ready, out_sum (ACC_W signed), out_count, out_ovf
// The slave modport is the accumulator side. The master modport is the
// producer/consumer side (multiplier upstream, sink downstream).
interface booth_dot_accum_if #(
    parameter int unsigned ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_product;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/booth_dot_accum.sv
// Sequential dot-product accumulator fed by 8-bit signed Booth products.
// Sums up to LEN terms per group (or fewer, closed early by in_last) into an
// ACC_W-bit signed accumulator and presents each result, its term count and a
// sticky signed-overflow flag in a held output register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : booth_dot_accum_if.slave (input product stream, output result stream)
module booth_dot_accum #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_dot_accum_if.slave    bus
);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    localparam logic [7:0] LenCnt = 8'(LEN);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       cnt_q;
    logic             ovf_q;
    logic [ACC_W-1:0] sum_q;
    logic [7:0]       count_q;
    logic             oflag_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       cnt_d;
    logic             ovf_d;
    logic             accept;
    logic             done;

    // acc/cnt/ovf are cleared whenever a group closes, so in StHold the same
    // add path yields "first term of the next group" without a separate mux.
    always_comb begin
        prod_ext = ACC_W'($signed(bus.in_product));
        acc_d    = acc_q + prod_ext;
        cnt_d    = cnt_q + 8'd1;
        // Overflow: operands share a sign and the wrapped result does not.
        ovf_d    = ovf_q | ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &
                            (acc_d[ACC_W-1] != acc_q[ACC_W-1]));
        done     = (cnt_d == LenCnt) | bus.in_last;
    end

    // out_ready -> in_ready is the only combinational input-to-output path.
    assign bus.in_ready  = (state_q == StAccum) | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;

    assign bus.out_valid = (state_q == StHold);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = oflag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oflag_q <= 1'b0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (done) begin
                            sum_q   <= acc_d;
                            count_q <= cnt_d;
                            oflag_q <= ovf_d;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                            state_q <= StHold;
                        end else begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            ovf_q   <= ovf_d;
                        end
                    end
                end
                StHold: begin
                    // accept implies out_ready here: the held result drains
                    // this edge regardless of whether a new beat arrives.
                    if (accept) begin
                        if (done) begin
                            sum_q   <= acc_d;
                            count_q <= cnt_d;
                            oflag_q <= ovf_d;
                        end else begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_d;
                            ovf_q   <= ovf_d;
                            state_q <= StAccum;
                        end
                    end else if (bus.out_ready) begin
                        state_q <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_dot_accum.sv
module tb_booth_dot_accum;

    localparam int unsigned LEN   = 8;
    localparam int unsigned ACC_W = 12;
    localparam int MaxV  = (1 << (ACC_W - 1)) - 1;
    localparam int MinV  = -(1 << (ACC_W - 1));
    localparam int Range = 1 << ACC_W;

    logic clk;
    logic rst_n;

    booth_dot_accum_if #(.ACC_W(ACC_W)) bus ();
    booth_dot_accum_if #(.ACC_W(8))     bus8 ();

    booth_dot_accum #(.LEN(LEN), .ACC_W(ACC_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    booth_dot_accum #(.LEN(2), .ACC_W(8)) u_ovf (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } res_t;

    res_t exp_q[$];
    int   n_vec;
    int   n_err;

    // Reference model state: exact integer arithmetic with explicit wrap.
    bit   m_hold;
    int   m_acc;
    int   m_cnt;
    bit   m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: inputs are stable at negedge; decide what the next posedge does.
    always @(negedge clk) begin
        bit   exp_ready;
        bit   hold_next;
        int   s;
        res_t r;
        if (!rst_n) begin
            m_hold = 1'b0;
            m_acc  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            exp_ready = !m_hold || bus.out_ready;
            chk("in_ready", int'(bus.in_ready), int'(exp_ready));
            chk("out_valid", int'(bus.out_valid), int'(m_hold));
            hold_next = m_hold && !bus.out_ready;
            if (bus.in_valid && exp_ready) begin
                s = m_acc + int'($signed(bus.in_product));
                if (s > MaxV) begin
                    s -= Range;
                    m_ovf = 1'b1;
                end else if (s < MinV) begin
                    s += Range;
                    m_ovf = 1'b1;
                end
                m_acc = s;
                m_cnt++;
                if (m_cnt == LEN || bus.in_last) begin
                    r.sum = m_acc;
                    r.cnt = m_cnt;
                    r.ovf = m_ovf;
                    exp_q.push_back(r);
                    m_acc = 0;
                    m_cnt = 0;
                    m_ovf = 1'b0;
                    hold_next = 1'b1;
                end
            end
            m_hold = hold_next;
        end
    end

    // Monitor: whenever a result is presented, compare against the queue head;
    // retire it when it is taken.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got sum %0d count %0d, expected none (t=%0t)",
                         $signed(bus.out_sum), bus.out_count, $time);
            end else begin
                e = exp_q[0];
                chk("out_sum", int'($signed(bus.out_sum)), e.sum);
                chk("out_count", int'(bus.out_count), e.cnt);
                chk("out_ovf", int'(bus.out_ovf), int'(e.ovf));
                if (bus.out_ready) exp_q.delete(0);
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input bit v, input logic [7:0] p, input bit l, input bit r);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_product = p;
        bus.in_last    = l;
        bus.out_ready  = r;
    endtask

    task automatic cyc8(input bit v, input logic [7:0] p);
        @(posedge clk);
        #1;
        bus8.in_valid   = v;
        bus8.in_product = p;
    endtask

    task automatic check_reset_outputs;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_count", int'(bus.out_count), 0);
        chk("rst_out_ovf", int'(bus.out_ovf), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst8_out_valid", int'(bus8.out_valid), 0);
    endtask

    task automatic reset_pulse;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_product  = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.in_product = '0;
        bus8.in_last    = 1'b0;
        bus8.out_ready  = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Overflow instance (LEN=2, ACC_W=8): 64+64 wraps to -128.
        cyc8(1'b1, 8'h40);
        cyc8(1'b1, 8'h40);
        cyc8(1'b0, 8'h00);
        @(negedge clk);
        chk("ovf_valid", int'(bus8.out_valid), 1);
        chk("ovf_sum", int'($signed(bus8.out_sum)), -128);
        chk("ovf_count", int'(bus8.out_count), 2);
        chk("ovf_flag", int'(bus8.out_ovf), 1);
        cyc8(1'b1, 8'h01);
        cyc8(1'b1, 8'h01);
        cyc8(1'b0, 8'h00);
        @(negedge clk);
        chk("ovf2_valid", int'(bus8.out_valid), 1);
        chk("ovf2_sum", int'($signed(bus8.out_sum)), 2);
        chk("ovf2_flag", int'(bus8.out_ovf), 0);

        // Full group of eight 64s.
        repeat (8) cyc(1'b1, 8'h40, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Early last: 7, -56, -8.
        cyc(1'b1, 8'h07, 1'b0, 1'b1);
        cyc(1'b1, 8'hC8, 1'b0, 1'b1);
        cyc(1'b1, 8'hF8, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: close a group, stall 5 cycles with a pending beat.
        repeat (3) cyc(1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 8'h05, 1'b0, 1'b0);
        cyc(1'b1, 8'h05, 1'b0, 1'b1);
        cyc(1'b1, 8'h06, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back streaming of alternating +1/-1.
        for (int i = 0; i < 24; i++) cyc(1'b1, (i % 2 == 0) ? 8'h01 : 8'hFF, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-group, then a clean group of eight 1s.
        repeat (3) cyc(1'b1, 8'd10, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        reset_pulse();
        repeat (8) cyc(1'b1, 8'h01, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic with random backpressure and early lasts.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(7) == 0),
                ($urandom_range(3) != 0));
        end

        repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
